// File: rtl/multicore_dm_arbiter.sv
// Round-robin sharing of one synchronous single-port data memory between cores,
// plus a start/finish sequencer that launches all cores and reports completion.
module multicore_dm_arbiter #(
  parameter int core_count = 4,
  parameter int reg_width  = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [core_count-1:0]           req,
  input  logic [core_count-1:0]           wr,
  input  logic [core_count*reg_width-1:0] addr,
  input  logic [core_count*reg_width-1:0] wdata,
  output logic [core_count-1:0]           ack,
  output logic [reg_width-1:0]            rdata,
  output logic [reg_width-1:0]            mem_addr,
  output logic [reg_width-1:0]            mem_wdata,
  output logic                            mem_we,
  input  logic [reg_width-1:0]            mem_rdata,
  input  logic                            run,
  input  logic [core_count-1:0]           endop,
  output logic [core_count-1:0]           core_start,
  output logic                            all_done
);

  localparam int IW = (core_count > 1) ? $clog2(core_count) : 1;

  typedef enum logic [1:0] {ARB, ACCESS, RESP} arb_state_t;
  typedef enum logic {IDLE, RUNNING} seq_state_t;
  typedef struct packed {
    logic [IW-1:0] idx;
    logic          wr;
  } grant_t;

  logic [core_count-1:0][reg_width-1:0] addr_v, wdata_v;
  assign addr_v  = addr;
  assign wdata_v = wdata;

  arb_state_t              arb_state;
  logic [IW-1:0]           ptr;
  grant_t                  cur;
  logic [core_count-1:0]   elig;
  logic                    grant_valid;
  logic [IW-1:0]           grant_idx;

  // The core being acked this cycle is masked so its held req is not regranted.
  assign elig = req & ~ack;

  always_comb begin
    int j;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int k = 1; k <= core_count; k++) begin
      j = int'(ptr) + k;
      if (j >= core_count) j = j - core_count;
      if (!grant_valid && elig[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arb_state <= ARB;
      ptr       <= IW'(core_count - 1);
      cur       <= '0;
      ack       <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      ack <= '0;
      case (arb_state)
        ARB: if (grant_valid) begin
          cur.idx   <= grant_idx;
          cur.wr    <= wr[grant_idx];
          mem_addr  <= addr_v[grant_idx];
          mem_wdata <= wdata_v[grant_idx];
          mem_we    <= wr[grant_idx];
          ptr       <= grant_idx;
          arb_state <= ACCESS;
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (cur.wr) begin
            ack[cur.idx] <= 1'b1;
            arb_state    <= ARB;
          end else begin
            arb_state <= RESP;
          end
        end
        RESP: begin
          rdata        <= mem_rdata;
          ack[cur.idx] <= 1'b1;
          arb_state    <= ARB;
        end
        default: arb_state <= ARB;
      endcase
    end
  end

  seq_state_t            seq_state;
  logic [core_count-1:0] done_mask;
  logic                  seq_clr;
  logic                  seq_set_en;

  // endop is ignored in the cycle core_start is out, so stale flags from the
  // previous run cannot complete the new one.
  assign seq_clr    = (seq_state == IDLE) && run;
  assign seq_set_en = (seq_state == RUNNING) && (core_start == '0);

  for (genvar i = 0; i < core_count; i++) begin : g_done
    always_ff @(posedge clk) begin
      if (reset || seq_clr)             done_mask[i] <= 1'b0;
      else if (seq_set_en && endop[i])  done_mask[i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_state  <= IDLE;
      core_start <= '0;
      all_done   <= 1'b0;
    end else begin
      core_start <= '0;
      case (seq_state)
        IDLE: if (run) begin
          core_start <= '1;
          all_done   <= 1'b0;
          seq_state  <= RUNNING;
        end
        RUNNING: if (seq_set_en && (&(done_mask | endop))) begin
          all_done  <= 1'b1;
          seq_state <= IDLE;
        end
        default: seq_state <= IDLE;
      endcase
    end
  end

endmodule
